// File: rtl/ttt_game_ctrl_if.sv
// ttt_game_ctrl_if: button/frame inputs and display snapshot outputs of the tic-tac-toe engine.
// master = button/timing source and renderer side, slave = game controller.
interface ttt_game_ctrl_if;
   logic        btn_up, btn_down, btn_left, btn_right, btn_place, btn_new, frame_start;
   logic [17:0] board_disp;
   logic [3:0]  cursor_disp;
   logic        turn_disp;
   logic [1:0]  state_disp, winner_disp;
   logic [8:0]  win_mask_disp;
   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_place, btn_new, frame_start,
      input  board_disp, cursor_disp, turn_disp, state_disp, winner_disp, win_mask_disp
   );
   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_place, btn_new, frame_start,
      output board_disp, cursor_disp, turn_disp, state_disp, winner_disp, win_mask_disp
   );
endinterface

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game-state engine with a frame-synchronous display snapshot.
// Define TTT_BTN_SYNC_EN to synchronize and edge-detect raw asynchronous button levels.
module ttt_game_ctrl #(
   parameter bit FIRST_PLAYER = 1'b0,
   parameter bit WRAP_CURSOR  = 1'b0,
   parameter bit FRAME_SYNC   = 1'b1
) (
   input logic            clk,
   input logic            RST_BTN,
   ttt_game_ctrl_if.slave bus
);
   typedef enum logic [1:0] {PLAY = 2'd0, WIN = 2'd1, DRAW = 2'd2, CHECK = 2'd3} state_t;
   localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1c0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
   localparam logic [35:0] RST_DISP = {18'd0, 4'd4, FIRST_PLAYER, 13'd0};

   logic [5:0] w_raw, w_btn;
   logic       w_new, w_place, w_up, w_down, w_left, w_right;
   assign w_raw = {bus.btn_new, bus.btn_place, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
`ifdef TTT_BTN_SYNC_EN
   logic [5:0] r_sync1, r_sync2, r_sync3;
   always_ff @(posedge clk or negedge RST_BTN)
      if (!RST_BTN) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   assign w_btn = r_sync2 & ~r_sync3;
`else
   assign w_btn = w_raw;
`endif
   assign {w_new, w_place, w_up, w_down, w_left, w_right} = w_btn;

   state_t      r_state, w_state_nx;
   logic [17:0] r_board, w_board_nx;
   logic [3:0]  r_cursor, w_cursor_nx, r_moves, w_moves_nx;
   logic        r_turn, w_turn_nx;
   logic [1:0]  r_winner, w_winner_nx;
   logic [8:0]  r_mask, w_mask_nx;
   logic [1:0]  w_row, w_col, w_mark;
   logic [3:0]  w_up_c, w_down_c, w_left_c, w_right_c;
   logic [8:0]  w_own, w_hit_mask;
   logic        w_empty;

   assign w_row     = r_cursor >= 4'd6 ? 2'd2 : r_cursor >= 4'd3 ? 2'd1 : 2'd0;
   assign w_col     = 2'(r_cursor - 4'd3 * {2'd0, w_row});
   assign w_up_c    = w_row == 2'd0 ? (WRAP_CURSOR ? r_cursor + 4'd6 : r_cursor) : r_cursor - 4'd3;
   assign w_down_c  = w_row == 2'd2 ? (WRAP_CURSOR ? r_cursor - 4'd6 : r_cursor) : r_cursor + 4'd3;
   assign w_left_c  = w_col == 2'd0 ? (WRAP_CURSOR ? r_cursor + 4'd2 : r_cursor) : r_cursor - 4'd1;
   assign w_right_c = w_col == 2'd2 ? (WRAP_CURSOR ? r_cursor - 4'd2 : r_cursor) : r_cursor + 4'd1;
   assign w_mark    = r_turn ? 2'b10 : 2'b01;
   assign w_empty   = r_board[{r_cursor, 1'b0} +: 2] == 2'b00;

   // Turn is still the placing player's during CHECK, so w_mark is the mark just placed.
   always_comb begin
      w_own      = '0;
      w_hit_mask = '0;
      for (int i = 0; i < 9; i++) w_own[i] = r_board[2*i +: 2] == w_mark;
      for (int l = 0; l < 8; l++) if ((w_own & LINES[l]) == LINES[l]) w_hit_mask = w_hit_mask | LINES[l];
   end

   always_comb begin
      w_state_nx  = r_state;
      w_board_nx  = r_board;
      w_cursor_nx = r_cursor;
      w_turn_nx   = r_turn;
      w_winner_nx = r_winner;
      w_mask_nx   = r_mask;
      w_moves_nx  = r_moves;
      if (w_new) begin
         w_state_nx  = PLAY;
         w_board_nx  = '0;
         w_cursor_nx = 4'd4;
         w_turn_nx   = FIRST_PLAYER;
         w_winner_nx = 2'b00;
         w_mask_nx   = '0;
         w_moves_nx  = '0;
      end else if (r_state == PLAY) begin
         if (w_place) begin
            if (w_empty) begin
               w_board_nx = r_board | ({16'd0, w_mark} << {r_cursor, 1'b0});
               w_moves_nx = r_moves + 4'd1;
               w_state_nx = CHECK;
            end
         end else
            w_cursor_nx = w_up ? w_up_c : w_down ? w_down_c : w_left ? w_left_c : w_right ? w_right_c : r_cursor;
      end else if (r_state == CHECK) begin
         if (|w_hit_mask) begin
            w_state_nx  = WIN;
            w_winner_nx = w_mark;
            w_mask_nx   = w_hit_mask;
         end else if (r_moves == 4'd9)
            w_state_nx = DRAW;
         else begin
            w_turn_nx  = ~r_turn;
            w_state_nx = PLAY;
         end
      end
   end

   always_ff @(posedge clk or negedge RST_BTN)
      if (!RST_BTN) begin
         r_state  <= PLAY;
         r_board  <= '0;
         r_cursor <= 4'd4;
         r_turn   <= FIRST_PLAYER;
         r_winner <= 2'b00;
         r_mask   <= '0;
         r_moves  <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_board  <= w_board_nx;
         r_cursor <= w_cursor_nx;
         r_turn   <= w_turn_nx;
         r_winner <= w_winner_nx;
         r_mask   <= w_mask_nx;
         r_moves  <= w_moves_nx;
      end

   // CHECK is internal bookkeeping; the renderer still sees PLAY.
   logic [35:0] w_live, w_disp;
   assign w_live = {r_board, r_cursor, r_turn, r_state == CHECK ? 2'b00 : 2'(r_state), r_winner, r_mask};

   if (FRAME_SYNC) begin : g_sync
      logic [35:0] r_disp;
      always_ff @(posedge clk or negedge RST_BTN)
         if (!RST_BTN) r_disp <= RST_DISP;
         else if (bus.frame_start) r_disp <= w_live;
      assign w_disp = r_disp;
   end else begin : g_live
      assign w_disp = w_live;
   end

   assign {bus.board_disp, bus.cursor_disp, bus.turn_disp, bus.state_disp, bus.winner_disp, bus.win_mask_disp} = w_disp;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: three controller configurations share one directed stimulus stream;
// a board-level game model predicts every display output each cycle.
module tb_ttt_game_ctrl;
   localparam int FP [3]  = '{0, 1, 0};
   localparam int WR [3]  = '{0, 1, 0};
   localparam int FSY [3] = '{0, 0, 1};
   localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   localparam logic [5:0] NEW = 6'b100000, PL = 6'b010000, UP = 6'b001000, DN = 6'b000100, LF = 6'b000010, RT = 6'b000001;

   logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0;
   logic [5:0] btns = '0;
   int nvec = 0, nerr = 0, ca = 4;
   always #5 clk = ~clk;

   ttt_game_ctrl_if ifa ();
   ttt_game_ctrl_if ifb ();
   ttt_game_ctrl_if ifc ();
   assign {ifa.btn_new, ifa.btn_place, ifa.btn_up, ifa.btn_down, ifa.btn_left, ifa.btn_right, ifa.frame_start} = {btns, fs};
   assign {ifb.btn_new, ifb.btn_place, ifb.btn_up, ifb.btn_down, ifb.btn_left, ifb.btn_right, ifb.frame_start} = {btns, fs};
   assign {ifc.btn_new, ifc.btn_place, ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right, ifc.frame_start} = {btns, fs};

   ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .WRAP_CURSOR(1'b0), .FRAME_SYNC(1'b0)) u_a (.clk(clk), .RST_BTN(rst_n), .bus(ifa));
   ttt_game_ctrl #(.FIRST_PLAYER(1'b1), .WRAP_CURSOR(1'b1), .FRAME_SYNC(1'b0)) u_b (.clk(clk), .RST_BTN(rst_n), .bus(ifb));
   ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .WRAP_CURSOR(1'b0), .FRAME_SYNC(1'b1)) u_c (.clk(clk), .RST_BTN(rst_n), .bus(ifc));

   logic [35:0] act [3];
   assign act[0] = {ifa.board_disp, ifa.cursor_disp, ifa.turn_disp, ifa.state_disp, ifa.winner_disp, ifa.win_mask_disp};
   assign act[1] = {ifb.board_disp, ifb.cursor_disp, ifb.turn_disp, ifb.state_disp, ifb.winner_disp, ifb.win_mask_disp};
   assign act[2] = {ifc.board_disp, ifc.cursor_disp, ifc.turn_disp, ifc.state_disp, ifc.winner_disp, ifc.win_mask_disp};

   // Model: cells 0 empty / 1 X / 2 O; phase 0 play, 1 awaiting line check, 2 won, 3 drawn.
   int mb [3][9];
   int mcur [3], mturn [3], mph [3], mwin [3], mmask [3], mmv [3];
   logic [35:0] snap [3];
   logic [35:0] exp_v;

   function automatic void mreset(input int k);
      for (int i = 0; i < 9; i++) mb[k][i] = 0;
      mcur[k] = 4; mturn[k] = FP[k]; mph[k] = 0; mwin[k] = 0; mmask[k] = 0; mmv[k] = 0;
   endfunction

   function automatic logic [35:0] live(input int k);
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mb[k][i]);
      return {b, 4'(mcur[k]), 1'(mturn[k]), 2'(mph[k] == 2 ? 1 : mph[k] == 3 ? 2 : 0), 2'(mwin[k]), 9'(mmask[k])};
   endfunction

   function automatic void step(input int k, input logic [5:0] b);
      int r, c, m, msk;
      r = mcur[k] / 3;
      c = mcur[k] % 3;
      if (b[5]) mreset(k);
      else if (mph[k] == 1) begin
         m = mturn[k] + 1;
         msk = 0;
         for (int l = 0; l < 8; l++)
            if (mb[k][LN[l][0]] == m && mb[k][LN[l][1]] == m && mb[k][LN[l][2]] == m)
               msk = msk | (1 << LN[l][0]) | (1 << LN[l][1]) | (1 << LN[l][2]);
         if (msk != 0) begin mph[k] = 2; mwin[k] = m; mmask[k] = msk; end
         else if (mmv[k] == 9) mph[k] = 3;
         else begin mturn[k] = 1 - mturn[k]; mph[k] = 0; end
      end else if (mph[k] == 0) begin
         if (b[4]) begin
            if (mb[k][mcur[k]] == 0) begin mb[k][mcur[k]] = mturn[k] + 1; mmv[k]++; mph[k] = 1; end
         end else if (b[3]) r = r > 0 ? r - 1 : (WR[k] != 0 ? 2 : 0);
         else if (b[2]) r = r < 2 ? r + 1 : (WR[k] != 0 ? 0 : 2);
         else if (b[1]) c = c > 0 ? c - 1 : (WR[k] != 0 ? 2 : 0);
         else if (b[0]) c = c < 2 ? c + 1 : (WR[k] != 0 ? 0 : 2);
         mcur[k] = r * 3 + c;
      end
   endfunction

   always @(posedge clk or negedge rst_n)
      for (int k = 0; k < 3; k++)
         if (!rst_n) begin mreset(k); snap[k] = live(k); end
         else begin
            if (fs) snap[k] = live(k);
            step(k, btns);
         end

   task automatic chk(input string name, input logic [17:0] a, input logic [17:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, a, e, $time);
      end
   endtask

   always @(negedge clk)
      for (int k = 0; k < 3; k++) begin
         exp_v = FSY[k] != 0 ? snap[k] : live(k);
         chk($sformatf("dut%0d.board", k),  18'(act[k][35:18]), 18'(exp_v[35:18]));
         chk($sformatf("dut%0d.cursor", k), 18'(act[k][17:14]), 18'(exp_v[17:14]));
         chk($sformatf("dut%0d.turn", k),   18'(act[k][13]),    18'(exp_v[13]));
         chk($sformatf("dut%0d.state", k),  18'(act[k][12:11]), 18'(exp_v[12:11]));
         chk($sformatf("dut%0d.winner", k), 18'(act[k][10:9]),  18'(exp_v[10:9]));
         chk($sformatf("dut%0d.mask", k),   18'(act[k][8:0]),   18'(exp_v[8:0]));
      end

   task automatic tick(input logic [5:0] b, input logic f);
      btns = b;
      fs = f;
      @(posedge clk);
      #1;
      btns = '0;
      fs = 1'b0;
   endtask

   task automatic place_at(input int t);
      while (ca / 3 > t / 3) begin tick(UP, 1'b0); ca -= 3; end
      while (ca / 3 < t / 3) begin tick(DN, 1'b0); ca += 3; end
      while (ca % 3 > t % 3) begin tick(LF, 1'b0); ca -= 1; end
      while (ca % 3 < t % 3) begin tick(RT, 1'b0); ca += 1; end
      tick(PL, 1'b0);
      tick('0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_cursor", 18'(ifa.cursor_disp), 18'd4);
      chk("rst_b_turn", 18'(ifb.turn_disp), 18'd1);
      chk("rst_c_board", 18'(ifc.board_disp), 18'd0);
      rst_n = 1'b1;
      tick(UP, 1'b0);
      tick(LF, 1'b0);
      chk("a_up_left", 18'(ifa.cursor_disp), 18'd0);
      tick(UP, 1'b0);
      chk("a_clamp_up", 18'(ifa.cursor_disp), 18'd0);
      chk("b_wrap_up", 18'(ifb.cursor_disp), 18'd6);
      chk("c_held_cursor", 18'(ifc.cursor_disp), 18'd4);
      ca = 0;
      tick(PL | RT, 1'b0);
      chk("a_place_beats_right", 18'(ifa.cursor_disp), 18'd0);
      chk("a_place_latency", ifa.board_disp, 18'h00001);
      tick('0, 1'b0);
      place_at(3);
      place_at(1);
      place_at(4);
      place_at(2);
      chk("a_win_state", 18'(ifa.state_disp), 18'd1);
      chk("a_win_winner", 18'(ifa.winner_disp), 18'd1);
      chk("a_win_mask", 18'(ifa.win_mask_disp), 18'h007);
      chk("a_win_board", ifa.board_disp, 18'b00_00_00_00_10_10_01_01_01);
      chk("b_win_winner", 18'(ifb.winner_disp), 18'd2);
      chk("b_win_mask", 18'(ifb.win_mask_disp), 18'h1c0);
      tick('0, 1'b1);
      chk("c_snap_win", 18'(ifc.win_mask_disp), 18'h007);
      tick(NEW | PL, 1'b0);
      ca = 4;
      chk("a_new_board", ifa.board_disp, 18'd0);
      chk("a_new_cursor", 18'(ifa.cursor_disp), 18'd4);
      chk("a_new_state", 18'(ifa.state_disp), 18'd0);
      chk("b_new_turn", 18'(ifb.turn_disp), 18'd1);
      tick('0, 1'b1);
      tick(PL, 1'b0);
      chk("a_x_at_4", ifa.board_disp, 18'h00100);
      chk("c_no_frame", ifc.board_disp, 18'd0);
      tick('0, 1'b0);
      chk("c_still_held", ifc.board_disp, 18'd0);
      tick('0, 1'b1);
      chk("c_frame_board", ifc.board_disp, 18'h00100);
      chk("c_frame_turn", 18'(ifc.turn_disp), 18'd1);
      tick(PL, 1'b0);
      tick('0, 1'b0);
      chk("a_occupied_board", ifa.board_disp, 18'h00100);
      chk("a_occupied_turn", 18'(ifa.turn_disp), 18'd1);
      tick(RT, 1'b1);
      ca = 5;
      chk("c_snap_pre_update", 18'(ifc.cursor_disp), 18'd4);
      chk("a_right", 18'(ifa.cursor_disp), 18'd5);
      tick('0, 1'b1);
      chk("c_snap_next_frame", 18'(ifc.cursor_disp), 18'd5);
      tick(NEW, 1'b0);
      ca = 4;
      place_at(0); place_at(1); place_at(2); place_at(4); place_at(3);
      place_at(5); place_at(7); place_at(6); place_at(8);
      chk("a_draw_state", 18'(ifa.state_disp), 18'd2);
      chk("a_draw_winner", 18'(ifa.winner_disp), 18'd0);
      chk("a_draw_mask", 18'(ifa.win_mask_disp), 18'd0);
      chk("b_draw_state", 18'(ifb.state_disp), 18'd2);
      tick('0, 1'b1);
      tick(NEW, 1'b0);
      ca = 4;
      tick(PL, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_a_board", ifa.board_disp, 18'd0);
      chk("rst_mid_a_cursor", 18'(ifa.cursor_disp), 18'd4);
      chk("rst_mid_a_state", 18'(ifa.state_disp), 18'd0);
      chk("rst_mid_c_board", ifc.board_disp, 18'd0);
      chk("rst_mid_b_turn", 18'(ifb.turn_disp), 18'd1);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick(DN, 1'b0);
      chk("a_after_reset_down", 18'(ifa.cursor_disp), 18'd7);
      tick('0, 1'b1);
      tick('0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
